// File: rtl/dff_pipe_pkg.sv
// Shared helpers for the dff_pipe_ff elastic register pipeline: majority vote,
// occupancy popcount and occupancy-width helper.
package dff_pipe_pkg;

  // Widest valid vector popcount accepts; DEPTH beyond this is not supported.
  localparam int POP_MAX = 256;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bit-wise vote; callers apply it per bit so it serves any data width.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [8:0] popcount(input logic [POP_MAX-1:0] v);
    logic [8:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX; i++) n = n + 9'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/dff_pipe_ff_stage.sv
// One pipeline stage: valid bit plus WIDTH-bit data with load enable.
// With DFF_PIPE_TMR_VOTE_EN defined the state is triplicated and self-scrubbing.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             c,
  input  logic             rst_b,
  input  logic             ld,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_out,
  output logic [WIDTH-1:0] d_out,
  output logic             mism
);

`ifdef DFF_PIPE_TMR_VOTE_EN
  logic             v_a, v_b, v_c;
  logic [WIDTH-1:0] d_a, d_b, d_c;
  logic             v_vote, v_nxt;
  logic [WIDTH-1:0] d_vote, d_nxt;

  // Copies reload the voted value even while holding, scrubbing a single upset.
  always_comb begin
    d_vote = '0;
    v_vote = maj3(v_a, v_b, v_c);
    for (int b = 0; b < WIDTH; b++) d_vote[b] = maj3(d_a[b], d_b[b], d_c[b]);
    v_nxt = ld ? v_in : v_vote;
    d_nxt = (ld && v_in) ? d_in : d_vote;
  end

  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      v_a <= 1'b0;
      v_b <= 1'b0;
      v_c <= 1'b0;
      d_a <= RST_VAL;
      d_b <= RST_VAL;
      d_c <= RST_VAL;
    end else begin
      v_a <= v_nxt;
      v_b <= v_nxt;
      v_c <= v_nxt;
      d_a <= d_nxt;
      d_b <= d_nxt;
      d_c <= d_nxt;
    end
  end

  assign v_out = v_vote;
  assign d_out = d_vote;
  assign mism  = (v_a != v_b) || (v_a != v_c) || (d_a != d_b) || (d_a != d_c);
`else
  logic             v_r;
  logic [WIDTH-1:0] d_r;

  // Bubbles never overwrite data, so the last word stays visible.
  always_ff @(posedge c or negedge rst_b) begin
    if (!rst_b) begin
      v_r <= 1'b0;
      d_r <= RST_VAL;
    end else if (ld) begin
      v_r <= v_in;
      if (v_in) d_r <= d_in;
    end
  end

  assign v_out = v_r;
  assign d_out = d_r;
  assign mism  = 1'b0;
`endif

endmodule

// File: rtl/dff_pipe_ff.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready, flush and occupancy.
// Optional triplicated state via DFF_PIPE_TMR_VOTE_EN (see dff_pipe_stage).
//
// Handshake: a word moves across an interface on a clock edge where valid and
// ready are both 1; valid never depends on ready, ready may depend on valid.
module dff_pipe_ff
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         c,
  input  logic                         rst_b,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             q,
  output logic [occ_width(DEPTH)-1:0]  occ,
  output logic                         tmr_err
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] mism;
  logic [WIDTH-1:0] data [DEPTH];

  // Ready ripples back from the output so a full pipe drains without a bubble.
  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0] && !clr && rst_b;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             v_src;
    logic [WIDTH-1:0] d_src;

    assign rdy[i] = !v[i] || rdy[i+1];

    if (i == 0) begin : g_head
      assign v_src = in_valid && in_ready;
      assign d_src = d;
    end else begin : g_body
      assign v_src = v[i-1];
      assign d_src = data[i-1];
    end

    // Flush forces every stage to load an empty slot, leaving data intact.
    dff_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .c     (c),
      .rst_b (rst_b),
      .ld    (rdy[i] || clr),
      .v_in  (clr ? 1'b0 : v_src),
      .d_in  (d_src),
      .v_out (v[i]),
      .d_out (data[i]),
      .mism  (mism[i])
    );
  end

  assign out_valid = v[DEPTH-1];
  assign q         = data[DEPTH-1];
  assign occ       = OCC_W'(popcount(POP_MAX'(v)));
  assign tmr_err   = |mism;

endmodule

// File: tb/tb_dff_pipe_ff.sv
// Bench for dff_pipe_ff: vector table, hand sequences and a queue-based model.
module tb_dff_pipe_ff;

  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 3;
  localparam logic [7:0] RST_VAL = 8'h5A;
  localparam int         OCC_W   = $clog2(DEPTH + 1);

  logic             c = 1'b0;
  logic             rst_b = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] q;
  logic [OCC_W-1:0] occ;
  logic             tmr_err;

  int compared = 0;
  int mismatched = 0;

  dff_pipe_ff #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .c         (c),
    .rst_b     (rst_b),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .occ       (occ),
    .tmr_err   (tmr_err)
  );

  // ---------------- clock ----------------
  always #5 c = ~c;

  // ---------------- reference model ----------------
  // Queue of words in flight, oldest first, each with its slot number.
  // A word advances one slot per cycle when the slot ahead is free or being vacated.
  logic [WIDTH-1:0] m_data[$];
  int               m_pos[$];
  logic [WIDTH-1:0] m_q = RST_VAL;

  function automatic logic m_in_ready(input logic cl, input logic ordy);
    return !cl && ((m_data.size() < DEPTH) || ordy);
  endfunction

  function automatic logic m_out_valid();
    return (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
  endfunction

  task automatic model_reset();
    m_data.delete();
    m_pos.delete();
    m_q = RST_VAL;
  endtask

  task automatic model_step(input logic iv, input logic [WIDTH-1:0] dd,
                            input logic ordy, input logic cl);
    logic acc, fire, mv, prev_moved;
    int   p, prev_pos;
    acc  = iv && m_in_ready(cl, ordy);
    fire = m_out_valid() && ordy;
    if (cl) begin
      m_data.delete();
      m_pos.delete();
    end else begin
      prev_pos   = DEPTH + 1;
      prev_moved = 1'b1;
      for (int k = 0; k < m_pos.size(); k++) begin
        p = m_pos[k];
        if (k == 0) mv = (p < DEPTH - 1) || fire;
        else        mv = (prev_pos != p + 1) || prev_moved;
        prev_pos   = p;
        prev_moved = mv;
        if (mv) m_pos[k] = p + 1;
      end
      if (fire) begin
        void'(m_data.pop_front());
        void'(m_pos.pop_front());
      end
      if (acc) begin
        m_data.push_back(dd);
        m_pos.push_back(0);
      end
      if (m_pos.size() > 0 && m_pos[0] == DEPTH - 1) m_q = m_data[0];
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("in_ready",  32'(in_ready),  32'(m_in_ready(clr, out_ready)));
    chk("out_valid", 32'(out_valid), 32'(m_out_valid()));
    chk("q",         32'(q),         32'(m_q));
    chk("occ",       32'(occ),       32'(m_data.size()));
    chk("tmr_err",   32'(tmr_err),   32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic iv, input logic [WIDTH-1:0] dd,
                        input logic ordy, input logic cl);
    in_valid  = iv;
    d         = dd;
    out_ready = ordy;
    clr       = cl;
  endtask

  task automatic tick();
    model_step(in_valid, d, out_ready, clr);
    @(posedge c);
    #1;
  endtask

  task automatic drive_cycle(input logic iv, input logic [WIDTH-1:0] dd,
                             input logic ordy, input logic cl);
    set_in(iv, dd, ordy, cl);
    #1;
    chk_model();
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] dd;
    logic             ordy;
    logic             cl;
    logic             e_ir;
    logic             e_ov;
    logic [WIDTH-1:0] e_q;
    int               e_occ;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic iv, input logic [7:0] dd, input logic ordy,
                              input logic cl, input logic e_ir, input logic e_ov,
                              input logic [7:0] e_q, input int e_occ);
    vec_t r;
    r.iv = iv; r.dd = dd; r.ordy = ordy; r.cl = cl;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_q = e_q; r.e_occ = e_occ;
    return r;
  endfunction

  initial begin
    // streaming 0x11,0x22,0x33 with out_ready held high
    tbl[0]  = mk(1, 8'h11, 1, 0,  1, 0, 8'h5A, 0);
    tbl[1]  = mk(1, 8'h22, 1, 0,  1, 0, 8'h5A, 1);
    tbl[2]  = mk(1, 8'h33, 1, 0,  1, 0, 8'h5A, 2);
    tbl[3]  = mk(0, 8'h00, 1, 0,  1, 1, 8'h11, 3);
    tbl[4]  = mk(0, 8'h00, 1, 0,  1, 1, 8'h22, 2);
    tbl[5]  = mk(0, 8'h00, 1, 0,  1, 1, 8'h33, 1);
    tbl[6]  = mk(0, 8'h00, 0, 0,  1, 0, 8'h33, 0);
    // back-pressure fill, then pass-through ready while full
    tbl[7]  = mk(1, 8'hA0, 0, 0,  1, 0, 8'h33, 0);
    tbl[8]  = mk(1, 8'hA1, 0, 0,  1, 0, 8'h33, 1);
    tbl[9]  = mk(1, 8'hA2, 0, 0,  1, 0, 8'h33, 2);
    tbl[10] = mk(1, 8'hA3, 0, 0,  0, 1, 8'hA0, 3);
    tbl[11] = mk(1, 8'hA3, 1, 0,  1, 1, 8'hA0, 3);
    tbl[12] = mk(0, 8'h00, 0, 0,  0, 1, 8'hA1, 3);
    tbl[13] = mk(0, 8'h00, 1, 0,  1, 1, 8'hA1, 3);
    // flush at occ=2 with an input offered; 0x55 must never enter
    tbl[14] = mk(1, 8'h55, 0, 1,  0, 1, 8'hA2, 2);
    tbl[15] = mk(0, 8'h00, 1, 0,  1, 0, 8'hA2, 0);
    tbl[16] = mk(0, 8'h00, 1, 0,  1, 0, 8'hA2, 0);

    // ---------------- reset and idle ----------------
    model_reset();
    repeat (3) @(posedge c);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q",         32'(q),         32'(RST_VAL));
    chk("rst_occ",       32'(occ),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_tmr_err",   32'(tmr_err),   32'd0);
    rst_b = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].iv, tbl[i].dd, tbl[i].ordy, tbl[i].cl);
      #1;
      chk($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_q", i),         32'(q),         32'(tbl[i].e_q));
      chk($sformatf("tbl%0d_occ", i),       32'(occ),       32'(tbl[i].e_occ));
      tick();
    end

    // ---------------- async reset mid-stream ----------------
    drive_cycle(1, 8'hC1, 0, 0);
    drive_cycle(1, 8'hC2, 0, 0);
    drive_cycle(1, 8'hC3, 0, 0);
    set_in(0, 8'h00, 0, 0);
    #1;
    chk("pre_rst_occ", 32'(occ), 32'(DEPTH));
    rst_b = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_q",         32'(q),         32'(RST_VAL));
    chk("mid_rst_occ",       32'(occ),       32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
    model_reset();
    @(posedge c);
    #2;
    rst_b = 1'b1;
    drive_cycle(1, 8'hD1, 1, 0);
    drive_cycle(0, 8'h00, 1, 0);

    // ---------------- randomized against model ----------------
    for (int n = 0; n < 600; n++) begin
      logic ordy;
      ordy = (n % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      drive_cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), ordy,
                  $urandom_range(0, 24) == 0);
    end

`ifdef DFF_PIPE_TMR_VOTE_EN
    // ---------------- single-copy upset scrub ----------------
    drive_cycle(0, 8'h00, 1, 1);
    drive_cycle(1, 8'h0F, 0, 0);
    drive_cycle(1, 8'h0F, 0, 0);
    drive_cycle(1, 8'h0F, 0, 0);
    set_in(0, 8'h00, 0, 0);
    force dut.g_stage[1].u_stage.d_b = 8'hFF;
    #1;
    release dut.g_stage[1].u_stage.d_b;
    #1;
    chk("tmr_err_pulse", 32'(tmr_err), 32'd1);
    chk("tmr_q_upset",   32'(q),       32'h0F);
    @(posedge c);
    #1;
    chk("tmr_err_clear", 32'(tmr_err), 32'd0);
    chk("tmr_scrubbed",  32'(dut.g_stage[1].u_stage.d_b), 32'h0F);
    chk("tmr_q_after",   32'(q),       32'h0F);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dff_pipe_ff.md
Name: dff_pipe_ff

Overview:
- Parametrised elastic register pipeline; successor to the single-bit async-reset DFF.
- Generalises to WIDTH-bit data and DEPTH stages, with valid/ready flow control, a synchronous flush and an occupancy count.
- Used wherever a multi-cycle, back-pressurable register chain must survive triplication.
- Optionally carries internal majority-voted (self-scrubbing) state.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1).
- RST_VAL, '0, data reset value (WIDTH bits) applied to every stage on rst_b.

Ports:
- c  input  1  clock; all state updates on posedge.
- rst_b  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous flush; drops all valid entries.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipeline accepts d this cycle.
- d  input  WIDTH  input data.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts q this cycle.
- q  output  WIDTH  last-stage data.
- occ  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.
- tmr_err  output  1  one-cycle pulse on a corrected voter mismatch; constant 0 without the macro.

Behaviour:
- Reset (rst_b low, async):
  - All stage valids = 0; all stage data = RST_VAL.
  - Outputs: out_valid=0, q=RST_VAL, occ=0, in_ready=0 during reset, tmr_err=0.
- Stages are numbered 0 (input) to DEPTH-1 (output).
- Stage ready is computed combinationally from the output back:
  - rdy[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - rdy[i] = !v[i] || rdy[i+1].
  - in_ready = rdy[0] && !clr.
- Stage i loads when rdy[i] is high:
  - Stage 0 takes d and v=in_valid&&in_ready.
  - Stage i>0 takes data[i-1] and v=v[i-1].
  - Otherwise the stage holds.
- Data registers load only when the incoming valid is 1. Bubbles never overwrite data, so q holds its last value while out_valid=0.
- Latency is DEPTH cycles from input handshake to out_valid with no stall. Throughput is 1 word/cycle.
- Full pipeline:
  - With all v=1 and out_ready=0: in_ready=0, no state change.
  - With out_ready=1 while full: in_ready=1 in the same cycle (pass-through ready chain, no bubble).
- clr:
  - Next cycle all v=0 and occ=0; data registers untouched.
  - Input offered during the clr cycle is not accepted (in_ready=0).
  - An output handshake in the clr cycle still completes: the downstream sees that word once.
- occ = popcount of v[], registered consistently with v (no extra latency).
- Reset mid-stream discards all entries immediately; first acceptance is in the first cycle after rst_b deasserts.
- DEPTH=1 degenerates to a single skid-free register with ready pass-through.

Optional Feature:
- Macro: DFF_PIPE_TMR_VOTE_EN.
- Defined:
  - Each stage's v and data are held in three copies A/B/C.
  - Every cycle each copy loads maj3(A,B,C) of its own next-state input, so a single upset copy is scrubbed on the next clock even when the stage holds.
  - All outputs are driven from voted values.
  - tmr_err pulses 1 for one cycle when any stage's copies disagree before voting.
- Undefined: a single copy per stage; tmr_err tied 0; no voting logic emitted.

Decomposition:
- Package dff_pipe_pkg holds:
  - function maj3 (WIDTH-generic via parameterised bit-wise and/or).
  - function popcount for occ.
  - localparam type helper for the occ width.
- One sub-module, dff_pipe_stage: WIDTH-bit data plus valid register with load enable. It contains the optional voting and produces a mismatch flag.
- Top instantiates DEPTH stages and builds the ready chain.

Test Plan:
- Reset and idle: hold rst_b=0 then release. Expect q=RST_VAL, out_valid=0, occ=0. In the first cycle after release, in_ready=1.
- Streaming (WIDTH=8, DEPTH=3, out_ready=1): send 0x11,0x22,0x33 back-to-back. Expect out_valid rising 3 cycles after the first handshake, q=0x11,0x22,0x33 on consecutive cycles, occ peaking at 3.
- Back-pressure:
  - Fill with 0xA0..0xA2 while out_ready=0. Expect occ=3 and in_ready=0.
  - Raise out_ready for 1 cycle with in_valid=1, d=0xA3. Expect 0xA0 consumed, 0xA3 accepted that same cycle, occ remains 3.
- Flush: with occ=2, assert clr for one cycle with in_valid=1, d=0x55. Expect in_ready=0, then occ=0 and out_valid=0. 0x55 never appears.
- Async reset mid-stream: pulse rst_b low between clock edges while occ=3. Expect out_valid=0 and q=RST_VAL immediately, with no clock edge required.
- With DFF_PIPE_TMR_VOTE_EN: force copy B of stage 1 data to 0xFF while stage holds 0x0F. Expect tmr_err=1 for one cycle, copy B restored to 0x0F next clock, q unaffected.
